// File: rtl/ps2_pkg.sv
// Shared types, Set-2 prefix/status constants and the hex-key lookup for the PS/2 scan-code decoder.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam int PS2_NUM_STATUS = 7;
  localparam logic [PS2_NUM_STATUS-1:0][7:0] PS2_STATUS_CODES = {
    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF
  };

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // Device replies (BAT result, echo, ack, resend, errors) that never map to keys.
  function automatic logic ps2_is_status(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_NUM_STATUS; i++) begin
      if (b == PS2_STATUS_CODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  // Returns {is_hex, digit}; non-hex codes yield all zeros.
  function automatic logic [4:0] ps2_hex_map(input logic [7:0] code);
    logic [4:0] r;
    case (code)
      8'h45:   r = {1'b1, 4'h0};
      8'h16:   r = {1'b1, 4'h1};
      8'h1E:   r = {1'b1, 4'h2};
      8'h26:   r = {1'b1, 4'h3};
      8'h25:   r = {1'b1, 4'h4};
      8'h2E:   r = {1'b1, 4'h5};
      8'h36:   r = {1'b1, 4'h6};
      8'h3D:   r = {1'b1, 4'h7};
      8'h3E:   r = {1'b1, 4'h8};
      8'h46:   r = {1'b1, 4'h9};
      8'h1C:   r = {1'b1, 4'hA};
      8'h32:   r = {1'b1, 4'hB};
      8'h21:   r = {1'b1, 4'hC};
      8'h23:   r = {1'b1, 4'hD};
      8'h24:   r = {1'b1, 4'hE};
      8'h2B:   r = {1'b1, 4'hF};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO: write lands at the clock edge, head visible the next cycle.
// Push into a full FIFO is accepted only when a pop happens on the same edge; pop while empty is ignored.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rd_dat = r_mem[r_rd_ptr];

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Folds Set-2 E0/F0/E1 prefixes into key events queued in a FWFT FIFO (1-cycle latency, valid/ready pop,
// drop + sticky ovf when full). PS2_HEX_MAP_EN adds the evt_hex/evt_is_hex head decode.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int SKIP_E1 = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [7:0]               evt_code,
  output logic                     evt_ext,
  output logic                     evt_break,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     ovf,
  input  logic                     ovf_clr
`ifdef PS2_HEX_MAP_EN
  ,
  output logic [3:0]               evt_hex,
  output logic                     evt_is_hex
`endif
);

  localparam int SKW = (SKIP_E1 < 2) ? 1 : $clog2(SKIP_E1 + 1);

  ps2_state_t       r_state;
  logic [SKW-1:0]   r_skip_cnt;
  logic             r_ovf;

  ps2_evt_t         w_evt;
  ps2_evt_t         w_head;
  logic [9:0]       w_rd_dat;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_is_prefix;
  logic             w_is_status;

  assign w_is_prefix = (byte_in == PS2_EXT) || (byte_in == PS2_BRK);
  assign w_is_status = ps2_is_status(byte_in);

  // Any byte that is not a prefix, a status reply, or part of a pause tail completes a key event.
  always_comb begin
    w_evt      = '0;
    w_evt.code = byte_in;
    w_evt.ext  = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
    w_evt.brk  = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
    w_push     = 1'b0;
    if (byte_valid && (r_state != ST_SKIP) && !w_is_prefix && !w_is_status) begin
      w_push = !((r_state == ST_IDLE) && (byte_in == PS2_PAUSE));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_skip_cnt <= '0;
    end else if (byte_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (byte_in == PS2_EXT) begin
            r_state <= ST_EXT;
          end else if (byte_in == PS2_BRK) begin
            r_state <= ST_BRK;
          end else if (byte_in == PS2_PAUSE) begin
            r_state    <= ST_SKIP;
            r_skip_cnt <= SKW'(SKIP_E1);
          end
        end
        ST_EXT: begin
          if (byte_in == PS2_BRK)      r_state <= ST_EXT_BRK;
          else if (byte_in != PS2_EXT) r_state <= ST_IDLE;
        end
        ST_BRK: begin
          if (byte_in == PS2_EXT)      r_state <= ST_EXT_BRK;
          else if (byte_in != PS2_BRK) r_state <= ST_IDLE;
        end
        ST_EXT_BRK: begin
          if (!w_is_prefix) r_state <= ST_IDLE;
        end
        ST_SKIP: begin
          r_skip_cnt <= r_skip_cnt - 1'b1;
          if (r_skip_cnt <= SKW'(1)) begin
            r_state    <= ST_IDLE;
            r_skip_cnt <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_pop = evt_ready && !w_empty;

  ps2_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (w_push),
    .wr_dat (w_evt),
    .pop    (evt_ready),
    .rd_dat (w_rd_dat),
    .full   (w_full),
    .empty  (w_empty),
    .count  (fifo_count)
  );

  // Set wins over clear so an overflow on the clearing cycle is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;

  // Unwritten RAM is never exposed: head fields read zero while empty.
  assign w_head    = w_empty ? ps2_evt_t'('0) : ps2_evt_t'(w_rd_dat);
  assign evt_valid = !w_empty;
  assign evt_code  = w_head.code;
  assign evt_ext   = w_head.ext;
  assign evt_break = w_head.brk;

`ifdef PS2_HEX_MAP_EN
  logic [4:0] w_hex;
  assign w_hex      = ps2_hex_map(w_head.code);
  assign evt_is_hex = !w_head.ext && w_hex[4];
  assign evt_hex    = w_head.ext ? 4'h0 : w_hex[3:0];
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: expected events queued at stimulus time, compared as the DUT pops them.
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [3:0] fifo_count;
  logic       ovf;
  logic       ovf_clr;
`ifdef PS2_HEX_MAP_EN
  logic [3:0] evt_hex;
  logic       evt_is_hex;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [9:0] sb[$];

  ps2_scancode_decoder #(.DEPTH(DEPTH), .SKIP_E1(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_ext    (evt_ext),
    .evt_break  (evt_break),
    .fifo_count (fifo_count),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
`ifdef PS2_HEX_MAP_EN
    ,
    .evt_hex    (evt_hex),
    .evt_is_hex (evt_is_hex)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_evt(input logic ext, input logic brk, input logic [7:0] code);
    sb.push_back({ext, brk, code});
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    evt_ready = 1'b1;
    while ((evt_valid || sb.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_sb_left"}, sb.size(), 0);
    check({tag, "_count0"}, fifo_count, 0);
  endtask

  // Scoreboard: every accepted head must match the oldest expected event.
  always @(negedge clk) begin : mon
    logic [9:0] e;
    if (!rst && evt_valid && evt_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_evt observed=%03h expected=none", {evt_ext, evt_break, evt_code});
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("evt", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, e});
      end
    end
  end

  initial begin
    rst        = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    evt_ready  = 1'b0;
    ovf_clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", evt_valid, 0);
    check("rst_code", evt_code, 0);
    check("rst_ext", evt_ext, 0);
    check("rst_break", evt_break, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", ovf, 0);
`ifdef PS2_HEX_MAP_EN
    check("rst_hex", evt_hex, 0);
    check("rst_is_hex", evt_is_hex, 0);
`endif
    rst = 1'b0;

    // Make then break of 1C, with first-event latency
    exp_evt(0, 0, 8'h1C);
    @(posedge clk); #1;
    byte_in    = 8'h1C;
    byte_valid = 1'b1;
    check("lat_pre_valid", evt_valid, 0);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    check("lat_post_valid", evt_valid, 1);
    check("lat_code", evt_code, 8'h1C);
    check("lat_count", fifo_count, 1);
    exp_evt(0, 1, 8'h1C);
    send(8'hF0);
    send(8'h1C);
    check("t1_count", fifo_count, 2);
    drain("t1");

    // Extended make/break, status bytes filtered, FSM returns to IDLE
    exp_evt(1, 0, 8'h75);
    send(8'hE0); send(8'h75);
    exp_evt(1, 1, 8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hAA); send(8'hFA); send(8'hF0); send(8'hFA);
    exp_evt(0, 0, 8'h16);
    send(8'h16);
    drain("t2");

    // Pause sequence swallowed entirely
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    exp_evt(0, 0, 8'h16);
    send(8'h16);
    drain("t3");

    // Overflow, clear, and full push-with-pop
    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < DEPTH) exp_evt(0, 0, 8'h15 + 8'(i));
      send(8'h15 + 8'(i));
    end
    check("full_count", fifo_count, 8);
    check("full_ovf", ovf, 1);
    check("full_head", evt_code, 8'h15);
    @(posedge clk); #1;
    byte_in    = 8'h30;
    byte_valid = 1'b1;
    ovf_clr    = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    ovf_clr    = 1'b0;
    check("ovf_clr_vs_set", ovf, 1);
    check("ovf_drop_count", fifo_count, 8);
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 0);
    exp_evt(0, 0, 8'h31);
    @(posedge clk); #1;
    byte_in    = 8'h31;
    byte_valid = 1'b1;
    evt_ready  = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    evt_ready  = 1'b0;
    check("pushpop_count", fifo_count, 8);
    check("pushpop_ovf", ovf, 0);
    check("pushpop_head", evt_code, 8'h16);
    drain("t4");

    // Reset mid-sequence with queued events
    evt_ready = 1'b0;
    send(8'h11); send(8'h12); send(8'h13);
    check("pre_rst_count", fifo_count, 3);
    send(8'hE0); send(8'hF0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_count", fifo_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_evt(0, 0, 8'h2E);
    send(8'h2E);
    check("post_rst_count", fifo_count, 1);
    check("post_rst_flags", {evt_ext, evt_break}, 2'b00);
    drain("t5");

`ifdef PS2_HEX_MAP_EN
    evt_ready = 1'b0;
    exp_evt(0, 0, 8'h45);
    send(8'h45);
    check("hex_45", {evt_is_hex, evt_hex}, 5'h10);
    drain("h1");
    evt_ready = 1'b0;
    exp_evt(0, 0, 8'h23);
    send(8'h23);
    check("hex_23", {evt_is_hex, evt_hex}, 5'h1D);
    drain("h2");
    evt_ready = 1'b0;
    exp_evt(1, 0, 8'h23);
    send(8'hE0); send(8'h23);
    check("hex_e0_23", {evt_is_hex, evt_hex}, 5'h00);
    drain("h3");
    evt_ready = 1'b0;
    exp_evt(0, 0, 8'h5A);
    send(8'h5A);
    check("hex_5a", {evt_is_hex, evt_hex}, 5'h00);
    drain("h4");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 receive stage and consumes its framed byte stream (one strobe per received byte).
- Folds Set-2 prefix sequences (E0 extended, F0 break, E1 pause) into single key events.
- Filters device status bytes.
- Buffers events in a small FIFO with a valid/ready interface for the CPU/MMIO side.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- SKIP_E1, 7, bytes discarded after an E1 prefix (pause sequence tail).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- byte_in  input  8  received scan-code byte, valid only with byte_valid
- byte_valid  input  1  one-cycle strobe per received byte
- evt_valid  output  1  FIFO head holds an event
- evt_ready  input  1  consumer accepts head this cycle
- evt_code  output  8  head event base code
- evt_ext  output  1  head event had E0 prefix
- evt_break  output  1  head event is release (F0 seen)
- fifo_count  output  $clog2(DEPTH)+1  occupancy
- ovf  output  1  sticky overflow flag
- ovf_clr  input  1  clears ovf
- evt_hex  output  4  hex digit of head event (only with PS2_HEX_MAP_EN)
- evt_is_hex  output  1  head is a hex key (only with PS2_HEX_MAP_EN)

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE, FIFO empty, skip counter 0.
  - Outputs: evt_valid=0, evt_code=0, evt_ext=0, evt_break=0, fifo_count=0, ovf=0, evt_hex=0, evt_is_hex=0.
  - A prefix sequence in progress is discarded.
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP. Transitions are evaluated only on cycles with byte_valid=1; otherwise hold.
- IDLE:
  - E0 -> EXT; F0 -> BRK.
  - E1 -> SKIP, counter loaded with SKIP_E1.
  - 00/AA/EE/FA/FC/FE/FF -> discarded, stay IDLE.
  - Any other byte -> push {ext=0, brk=0, code}.
- EXT: F0 -> EXT_BRK; E0 -> stay; status byte -> discard, IDLE; other -> push {1,0,code}, IDLE.
- BRK: E0 -> EXT_BRK; F0 -> stay; status byte -> discard, IDLE; other -> push {0,1,code}, IDLE.
- EXT_BRK: E0/F0 -> stay; status byte -> discard, IDLE; other -> push {1,1,code}, IDLE.
- SKIP: each byte decrements the counter; on the byte that reaches 0, go to IDLE. No events are pushed.
- Latency: event is written at the edge sampling byte_valid. evt_valid and head fields are valid the following cycle (1 cycle). Head fields are combinational from the FIFO head (first-word fall-through).
- Pop: occurs when evt_valid && evt_ready at a clock edge. evt_ready while empty is ignored.
- Full:
  - Push without pop -> event dropped, ovf set.
  - Push with simultaneous pop -> both performed, count unchanged, no ovf.
- Empty with simultaneous push and pop: the pop is ignored and the push is performed.
- ovf is sticky until ovf_clr=1. If ovf_clr and a new overflow coincide, ovf stays 1.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.

Optional Feature:
- Macro: PS2_HEX_MAP_EN.
- Defined: adds evt_hex/evt_is_hex, decoded combinationally from head evt_code when evt_ext=0.
  - Codes 45,16,1E,26,25,2E,36,3D,3E,46 -> 0..9.
  - Codes 1C,32,21,23,24,2B -> A..F.
  - Any other code, or evt_ext=1 -> evt_is_hex=0, evt_hex=0.
- Undefined: both ports and the mapping logic are absent. All other behaviour is identical.

Decomposition:
- Package ps2_pkg:
  - FSM state enum.
  - Constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1.
  - Status-code list.
  - Event struct {ext, brk, code[7:0]}.
  - Hex map function (used under the macro).
- One sub-module: ps2_evt_fifo, a synchronous FWFT FIFO with parameter DEPTH, 10-bit wide, providing push/pop/full/empty/count.

Test Plan:
- Bytes 1C, then F0 1C -> events {0,0,1C} then {0,1,1C}; evt_valid rises 1 cycle after the first strobe.
- Bytes E0 75, E0 F0 75 -> events {1,0,75}, {1,1,75}. Bytes AA, FA, F0 FA interleaved -> no events, FSM back in IDLE.
- E1 14 77 E1 F0 14 F0 77 then 16 -> exactly one event {0,0,16}.
- evt_ready=0, push 9 make codes with DEPTH=8 -> fifo_count=8, ovf=1, head is the first code. Then ovf_clr -> ovf=0. Push on the same cycle as pop while full -> count stays 8, ovf stays 0.
- Assert rst while in EXT_BRK with 3 queued events; release rst, send 2E -> single event {0,0,2E}; no stale data in FIFO.
- With PS2_HEX_MAP_EN: 45 -> hex 0, is_hex 1; 23 -> hex D; E0 23 -> is_hex 0; 5A -> is_hex 0.
